ex_mem_latch: RTL

- Execute→memory pipeline register for the 5-stage MIPS pipeline.
- Captures execute-stage results and holds the MEM-stage copies (ALUOut_me, lui_me, npc_me, regDst_me, regWr_me, regSel_me, dmemload_me) that the forwarding unit and the MEM/WB latch consume.
- Owns the data-memory request handshake: holds dmemREN/dmemWEN until dhit and stalls upstream while the request is outstanding.

---
 rtl/ex_mem_latch.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ex_mem_latch.sv
// ex_mem_latch -- execute-to-memory pipeline register with data-memory handshake.
//
// Purpose:
//   Captures execute-stage results into MEM-stage registers. It also owns the
//   data-memory request: a captured load or store keeps dmemREN/dmemWEN high
//   until dhit. While that request is outstanding, upstream is stalled.
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   stall_in, flush       hold-off from downstream/hazard unit; bubble insert
//   *_ex                  execute-stage values to capture
//   dhit, dmemload        data-memory acknowledge and read data
//   dmemREN, dmemWEN      data-memory requests (only while REQ)
//   dmemaddr, dmemstore   address (= ALUOut_me) and latched store data
//   *_me                  MEM-stage copies for forwarding and MEM/WB latch
//   mem_busy              request outstanding; upstream must hold
//
// state | meaning
// IDLE  | no memory op in this entry; free to capture
// REQ   | load/store outstanding; requests driven, capture blocked
// DONE  | memory op acknowledged; free to capture
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              stall_in,
  input  logic              flush,
  input  logic [WORD_W-1:0] ALUOut_ex,
  input  logic [WORD_W-1:0] lui_ex,
  input  logic [WORD_W-1:0] npc_ex,
  input  logic [WORD_W-1:0] store_ex,
  input  logic [REG_W-1:0]  regDst_ex,
  input  logic              regWr_ex,
  input  logic [1:0]        regSel_ex,
  input  logic              dREN_ex,
  input  logic              dWEN_ex,
  input  logic              halt_ex,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic [WORD_W-1:0] ALUOut_me,
  output logic [WORD_W-1:0] lui_me,
  output logic [WORD_W-1:0] npc_me,
  output logic [WORD_W-1:0] dmemload_me,
  output logic [REG_W-1:0]  regDst_me,
  output logic              regWr_me,
  output logic [1:0]        regSel_me,
  output logic              halt_me,
  output logic              mem_busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state;
  logic [WORD_W-1:0] aluOutQ, luiQ, npcQ, storeQ, loadQ;
  logic [REG_W-1:0]  regDstQ;
  logic              regWrQ, dRenQ, dWenQ, haltQ;
  logic [1:0]        regSelQ;
  logic              adv;
  logic              isMemOp;

  assign mem_busy = (state == REQ);
  assign adv      = ~mem_busy & ~stall_in;
  assign isMemOp  = dREN_ex | dWEN_ex;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      aluOutQ <= '0;
      luiQ    <= '0;
      npcQ    <= '0;
      storeQ  <= '0;
      loadQ   <= '0;
      regDstQ <= '0;
      regWrQ  <= 1'b0;
      regSelQ <= 2'b00;
      dRenQ   <= 1'b0;
      dWenQ   <= 1'b0;
      haltQ   <= 1'b0;
    end else if (state == REQ) begin
      // flush arriving with dhit is left for the next capture edge
      if (dhit) begin
        if (dRenQ) loadQ <= dmemload;
        state <= DONE;
      end
    end else if (adv) begin
      if (flush) begin
        state   <= IDLE;
        aluOutQ <= '0;
        luiQ    <= '0;
        npcQ    <= '0;
        storeQ  <= '0;
        regDstQ <= '0;
        regWrQ  <= 1'b0;
        regSelQ <= 2'b00;
        dRenQ   <= 1'b0;
        dWenQ   <= 1'b0;
        haltQ   <= 1'b0;
      end else begin
        state   <= isMemOp ? REQ : IDLE;
        aluOutQ <= ALUOut_ex;
        luiQ    <= lui_ex;
        npcQ    <= npc_ex;
        storeQ  <= store_ex;
        regDstQ <= regDst_ex;
        regWrQ  <= regWr_ex;
        regSelQ <= regSel_ex;
        // both set is illegal; it is resolved as a store
        dRenQ   <= dREN_ex & ~dWEN_ex;
        dWenQ   <= dWEN_ex;
        haltQ   <= halt_ex;
      end
    end
  end

  assign dmemREN     = mem_busy & dRenQ;
  assign dmemWEN     = mem_busy & dWenQ;
  assign dmemaddr    = aluOutQ;
  assign dmemstore   = storeQ;
  assign ALUOut_me   = aluOutQ;
  assign lui_me      = luiQ;
  assign npc_me      = npcQ;
  assign dmemload_me = loadQ;
  assign regDst_me   = regDstQ;
  assign regWr_me    = regWrQ;
  assign regSel_me   = regSelQ;
  assign halt_me     = haltQ;

endmodule
